// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 MIPS general-purpose register file fed by the WB stage.
// Two combinational read ports for ID with write-to-read bypass, one
// registered debug read port for dumping the registers after halt, and a
// saturating count of committed writes.
module reg_file_wb #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               wr_en_i,
  input  logic [NB_ADDR-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic [NB_ADDR-1:0] rs_addr_i,
  input  logic [NB_ADDR-1:0] rt_addr_i,
  output logic [NB_DATA-1:0] rs_data_o,
  output logic [NB_DATA-1:0] rt_data_o,
  input  logic [NB_ADDR-1:0] dbg_addr_i,
  input  logic               dbg_rd_i,
  output logic [NB_DATA-1:0] dbg_data_o,
  output logic               dbg_valid_o,
  output logic [15:0]        wr_count_o
);

  logic [NB_DATA-1:0] r_regs [N_REGS];
  logic [NB_DATA-1:0] r_dbgData;
  logic               r_dbgValid;
  logic [15:0]        r_wrCount;

  logic               w_wrCommit;
  logic [NB_DATA-1:0] w_rsData;
  logic [NB_DATA-1:0] w_rtData;
  logic [NB_DATA-1:0] w_dbgData;

  // A write takes effect only when the pipeline steps and the target is not $zero
  always_comb begin
    w_wrCommit = enable_i && wr_en_i && (wr_addr_i != '0);
  end

  // Read port A: $zero reads 0, a same-cycle commit to the address wins over the array
  always_comb begin
    w_rsData = r_regs[rs_addr_i];
    if (rs_addr_i == '0) begin
      w_rsData = '0;
    end else if (w_wrCommit && (rs_addr_i == wr_addr_i)) begin
      w_rsData = wr_data_i;
    end
  end

  // Read port B: same selection rule as port A
  always_comb begin
    w_rtData = r_regs[rt_addr_i];
    if (rt_addr_i == '0) begin
      w_rtData = '0;
    end else if (w_wrCommit && (rt_addr_i == wr_addr_i)) begin
      w_rtData = wr_data_i;
    end
  end

  // Debug capture source: same bypass rule so a write in the strobe cycle is visible
  always_comb begin
    w_dbgData = r_regs[dbg_addr_i];
    if (dbg_addr_i == '0) begin
      w_dbgData = '0;
    end else if (w_wrCommit && (dbg_addr_i == wr_addr_i)) begin
      w_dbgData = wr_data_i;
    end
  end

  // State update: reset clears everything; a stalled step holds all but the valid pulse
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_dbgData  <= '0;
      r_dbgValid <= 1'b0;
      r_wrCount  <= '0;
    end else if (enable_i) begin
      if (w_wrCommit) begin
        r_regs[wr_addr_i] <= wr_data_i;
        if (r_wrCount != 16'hFFFF) begin
          r_wrCount <= r_wrCount + 16'd1;
        end
      end
      r_dbgValid <= dbg_rd_i;
      if (dbg_rd_i) begin
        r_dbgData <= w_dbgData;
      end
    end else begin
      r_dbgValid <= 1'b0;
    end
  end

  assign rs_data_o   = w_rsData;
  assign rt_data_o   = w_rtData;
  assign dbg_data_o  = r_dbgData;
  assign dbg_valid_o = r_dbgValid;
  assign wr_count_o  = r_wrCount;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench for reg_file_wb. Stimulus pushes expected
// values into queues; a negedge monitor pops and compares them.
module tb_reg_file_wb;

  logic        clock_i;
  logic        reset_i;
  logic        enable_i;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;
  logic [4:0]  dbg_addr_i;
  logic        dbg_rd_i;
  logic [31:0] dbg_data_o;
  logic        dbg_valid_o;
  logic [15:0] wr_count_o;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } combItem_t;

  typedef struct {
    int          due;
    logic [31:0] exp;
  } dbgItem_t;

  localparam int SEL_RS    = 0;
  localparam int SEL_RT    = 1;
  localparam int SEL_COUNT = 2;
  localparam int SEL_VALID = 3;
  localparam int SEL_DDATA = 4;

  combItem_t combQ[$];
  dbgItem_t  dbgQ[$];
  int        cyc;
  int        errors;
  int        checks;

  reg_file_wb #(
    .NB_DATA(32),
    .NB_ADDR(5),
    .N_REGS (32)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rs_addr_i  (rs_addr_i),
    .rt_addr_i  (rt_addr_i),
    .rs_data_o  (rs_data_o),
    .rt_data_o  (rt_data_o),
    .dbg_addr_i (dbg_addr_i),
    .dbg_rd_i   (dbg_rd_i),
    .dbg_data_o (dbg_data_o),
    .dbg_valid_o(dbg_valid_o),
    .wr_count_o (wr_count_o)
  );

  // Free-running clock
  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Cycle index used to schedule debug responses
  always @(posedge clock_i) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic rst, input logic en, input logic we,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic dbgRd, input logic [4:0] dbgAddr);
    @(posedge clock_i);
    #1;
    reset_i    = rst;
    enable_i   = en;
    wr_en_i    = we;
    wr_addr_i  = waddr;
    wr_data_i  = wdata;
    rs_addr_i  = rs;
    rt_addr_i  = rt;
    dbg_rd_i   = dbgRd;
    dbg_addr_i = dbgAddr;
  endtask

  task automatic expectComb(input int sel, input logic [31:0] exp);
    combItem_t it;
    it.sel = sel;
    it.exp = exp;
    combQ.push_back(it);
  endtask

  task automatic expectDbg(input logic [31:0] exp);
    dbgItem_t it;
    it.due = cyc + 1;
    it.exp = exp;
    dbgQ.push_back(it);
  endtask

  function automatic logic [31:0] pattern(input int a);
    return 32'hA5A50000 + a;
  endfunction

  // Register contents going into the debug sweep
  function automatic logic [31:0] sweepValue(input int a);
    if (a == 0) return 32'h0;
    if (a == 7) return 32'h12345678;
    if (a == 9) return 32'h99999999;
    return pattern(a);
  endfunction

  // Monitor: compares this cycle's combinational expectations and any due debug response
  always @(negedge clock_i) begin
    while (combQ.size() > 0) begin
      combItem_t it;
      it = combQ.pop_front();
      case (it.sel)
        SEL_RS:    checkOutput("rs_data", rs_data_o, it.exp);
        SEL_RT:    checkOutput("rt_data", rt_data_o, it.exp);
        SEL_COUNT: checkOutput("wr_count", {16'h0, wr_count_o}, it.exp);
        SEL_VALID: checkOutput("dbg_valid", {31'h0, dbg_valid_o}, it.exp);
        default:   checkOutput("dbg_data_hold", dbg_data_o, it.exp);
      endcase
    end
    if (dbgQ.size() > 0 && dbgQ[0].due == cyc) begin
      dbgItem_t d;
      d = dbgQ.pop_front();
      checkOutput("dbg_valid_pulse", {31'h0, dbg_valid_o}, 32'h1);
      checkOutput("dbg_data", dbg_data_o, d.exp);
    end else if (dbg_valid_o === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL dbg_unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    cyc        = 0;
    errors     = 0;
    checks     = 0;
    reset_i    = 1'b1;
    enable_i   = 1'b0;
    wr_en_i    = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    rs_addr_i  = '0;
    rt_addr_i  = '0;
    dbg_rd_i   = 1'b0;
    dbg_addr_i = '0;
    repeat (2) @(posedge clock_i);

    // Post-reset: every address reads 0 on A, B and debug
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b1, 5'(a));
      expectComb(SEL_RS, 32'h0);
      expectComb(SEL_RT, 32'h0);
      if (a == 0) begin
        expectComb(SEL_COUNT, 32'h0);
        expectComb(SEL_VALID, 32'h0);
      end
      expectDbg(32'h0);
    end

    // Fill registers 1..31; port A sees each write through the bypass
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 5'(a), pattern(a), 5'(a), 5'd0, 1'b0, 5'd0);
      expectComb(SEL_RS, pattern(a));
      expectComb(SEL_RT, 32'h0);
    end

    // Read back stored values
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(32 - a), 1'b0, 5'd0);
      expectComb(SEL_RS, pattern(a));
      expectComb(SEL_RT, pattern(32 - a));
      if (a == 1) expectComb(SEL_COUNT, 32'd31);
    end

    // Writes to $zero are discarded and not counted
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    expectComb(SEL_RS, 32'h0);
    expectComb(SEL_RT, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b0, 5'd0);
    expectComb(SEL_RS, 32'h0);
    expectComb(SEL_RT, pattern(1));
    expectComb(SEL_COUNT, 32'd31);

    // Dual bypass on reg 7, then the stored value
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0, 5'd0);
    expectComb(SEL_RS, 32'h12345678);
    expectComb(SEL_RT, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0, 5'd0);
    expectComb(SEL_RS, 32'h12345678);
    expectComb(SEL_RT, pattern(8));
    expectComb(SEL_COUNT, 32'd32);

    // Debug capture of a same-cycle write to reg 9
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd9, 32'h99999999, 5'd9, 5'd10, 1'b1, 5'd9);
    expectComb(SEL_RS, 32'h99999999);
    expectComb(SEL_RT, pattern(10));
    expectDbg(32'h99999999);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    expectComb(SEL_RS, 32'h99999999);
    expectComb(SEL_COUNT, 32'd33);

    // Stalled step: write, bypass and debug strobe all ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000CAFE, 5'd5, 5'd5, 1'b1, 5'd3);
    expectComb(SEL_RS, pattern(5));
    expectComb(SEL_RT, pattern(5));
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    expectComb(SEL_RS, pattern(5));
    expectComb(SEL_COUNT, 32'd33);
    expectComb(SEL_VALID, 32'h0);
    expectComb(SEL_DDATA, 32'h99999999);

    // Debug sweep with a reset (plus a write that must be dropped) at step 20
    for (int i = 0; i < 32; i++) begin
      if (i == 20) begin
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'(i));
      end else begin
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, 5'(i));
        if (i < 20) begin
          expectDbg(sweepValue(i));
        end else begin
          expectDbg(32'h0);
          expectComb(SEL_RS, 32'h0);
          expectComb(SEL_RT, 32'h0);
        end
        if (i == 21) begin
          expectComb(SEL_VALID, 32'h0);
          expectComb(SEL_COUNT, 32'h0);
        end
      end
    end

    // Drain the last debug response and make sure nothing stays outstanding
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(posedge clock_i);
    #1;
    checkOutput("dbg_queue_drained", 32'(dbgQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32x32 MIPS general-purpose register file. It is the write-back consumer of the WB-stage write-data select mux.
- Accepts one write per cycle from WB: the data is the mux output, plus write address and write-enable.
- Serves two combinational read ports to the ID stage, with internal write-to-read bypass.
- Serves one registered debug read port to the FPGA debug unit, which dumps all registers after halt.

Parameters:
- NB_DATA, 32, register width in bits
- NB_ADDR, 5, register address width
- N_REGS, 32, number of registers (must equal 2**NB_ADDR)

Ports:
- clock_i  in  1  system clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  pipeline step enable; writes and debug captures occur only when high
- wr_en_i  in  1  WB register-write enable
- wr_addr_i  in  NB_ADDR  WB destination register
- wr_data_i  in  NB_DATA  WB data (write-data mux output)
- rs_addr_i  in  NB_ADDR  read port A address
- rt_addr_i  in  NB_ADDR  read port B address
- rs_data_o  out  NB_DATA  read port A data
- rt_data_o  out  NB_DATA  read port B data
- dbg_addr_i  in  NB_ADDR  debug read address
- dbg_rd_i  in  1  debug read strobe
- dbg_data_o  out  NB_DATA  debug read data, registered
- dbg_valid_o  out  1  one-cycle pulse marking dbg_data_o valid
- wr_count_o  out  16  number of committed writes since reset, saturating

Behaviour:
- Reset (synchronous, reset_i high at rising edge):
  - All registers cleared to 0.
  - dbg_data_o = 0, dbg_valid_o = 0, wr_count_o = 0.
  - Reset overrides any simultaneous write or debug read.
- Write commit:
  - Condition: rising edge with enable_i=1, wr_en_i=1, wr_addr_i != 0, reset_i=0.
  - Effect: regs[wr_addr_i] <= wr_data_i and wr_count_o increments.
  - wr_count_o saturates at 16'hFFFF and does not wrap.
- Register 0:
  - Always reads 0 on every port, including debug.
  - Writes to address 0 are discarded and not counted.
- enable_i=0:
  - Register array, wr_count_o and debug outputs hold.
  - Exception: dbg_valid_o is forced to 0 on that edge.
- Read ports A and B:
  - Purely combinational, zero latency.
  - Bypass rule: if enable_i=1, wr_en_i=1, wr_addr_i != 0, and the read address equals wr_addr_i, the port returns wr_data_i in the same cycle (write-before-read within the cycle).
  - Otherwise the port returns the stored value.
  - Both ports may bypass simultaneously.
- Debug port:
  - On an edge with dbg_rd_i=1 and enable_i=1, dbg_data_o captures the value at dbg_addr_i, and dbg_valid_o=1 on the next cycle only.
  - The capture uses the pre-edge array plus the same bypass rule, so a same-cycle write is visible.
  - Without a strobe: dbg_valid_o=0 and dbg_data_o holds its last value.
  - Back-to-back strobes give valid on consecutive cycles, each with its own address's data.
  - Latency: exactly 1 cycle from strobe to valid.
- Widths:
  - No arithmetic apart from the counter.
  - Addresses >= N_REGS are impossible when N_REGS = 2**NB_ADDR.
- Reset mid-operation:
  - A pending debug read is dropped; no valid pulse follows the reset edge.
  - Contents written before reset are not observable after it; all reads return 0.

Test Plan:
- Reset, then read all 32 addresses on A, B and debug -> all 0, wr_count_o=0, dbg_valid_o=0.
- Write regs 1..31 with value 32'hA5A50000+addr at enable_i=1, then read back -> each address returns its pattern; wr_count_o=31.
- Write 32'hDEADBEEF to reg 0, then read rs_addr_i=0 -> 0; wr_count_o unchanged.
- Same cycle: wr_addr_i=7, wr_data_i=32'h12345678, rs_addr_i=7, rt_addr_i=7 -> both outputs 32'h12345678 combinationally; next cycle the stored value is the same.
- enable_i=0 with wr_en_i=1 to reg 5 (32'hCAFE) -> reg 5 unchanged; bypass inactive; count unchanged.
- Debug sweep: dbg_rd_i high for 32 cycles on addresses 0..31 -> dbg_valid_o high for 32 consecutive cycles starting one cycle later, with matching data. Assert reset_i mid-sweep -> next cycle dbg_valid_o=0 and subsequent reads return 0.
